// File: rtl/des_arbiter_if.sv
// Request, core and response bundle for the DES core arbiter.
// The master side is the requester/core environment; the slave side is the arbiter.
interface des_arbiter_if #(
  parameter int NREQ = 4
);
  logic               enable_i;
  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [NREQ-1:0]    req_mode_i;
  logic [NREQ*64-1:0] req_key_i;
  logic [NREQ*64-1:0] req_data_i;
  logic               core_valid_o;
  logic               core_mode_o;
  logic [63:0]        core_key_o;
  logic [63:0]        core_data_o;
  logic               core_valid_i;
  logic [63:0]        core_data_i;
  logic [NREQ-1:0]    rsp_valid_o;
  logic [63:0]        rsp_data_o;
  logic               busy_o;
  logic               err_o;

  modport master (
    output enable_i,
    output req_valid_i,
    output req_mode_i,
    output req_key_i,
    output req_data_i,
    output core_valid_i,
    output core_data_i,
    input  req_ready_o,
    input  core_valid_o,
    input  core_mode_o,
    input  core_key_o,
    input  core_data_o,
    input  rsp_valid_o,
    input  rsp_data_o,
    input  busy_o,
    input  err_o
  );

  modport slave (
    input  enable_i,
    input  req_valid_i,
    input  req_mode_i,
    input  req_key_i,
    input  req_data_i,
    input  core_valid_i,
    input  core_data_i,
    output req_ready_o,
    output core_valid_o,
    output core_mode_o,
    output core_key_o,
    output core_data_o,
    output rsp_valid_o,
    output rsp_data_o,
    output busy_o,
    output err_o
  );
endinterface

// File: rtl/des_arbiter.sv
// Round-robin sharing of one pipelined DES core among NREQ requesters,
// with an owner-tag pipeline that routes each core result back to its issuer.
module des_arbiter #(
  parameter int NREQ         = 4,
  parameter int CORE_LATENCY = 19,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  des_arbiter_if.slave   bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // core output appears one edge after its last internal stage
  localparam int TD = CORE_LATENCY + 1;
  localparam logic [4:0] MAXI = 5'(MAX_INFLIGHT);

  logic [IW-1:0]   ptr_q;
  logic [4:0]      infl_q [NREQ];
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic [IW-1:0]   gidx;

  logic            iv_q;
  logic            imode_q;
  logic [63:0]     ikey_q;
  logic [63:0]     idata_q;
  logic [IW-1:0]   iown_q;

  logic            tv_q [TD];
  logic [IW-1:0]   to_q [TD];
  logic            tail_v;
  logic [IW-1:0]   tail_o;
  logic            hit;

  logic [NREQ-1:0] rsp_q;
  logic [63:0]     rdata_q;
  logic            err_q;
  logic            busy;

  function automatic logic [IW-1:0] wrap(
    input logic [IW-1:0] p,
    input int            i
  );
    int s;
    s = int'(p) + i;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  always_comb begin
    elig = '0;
    for (int n = 0; n < NREQ; n++)
      elig[n] = bus.enable_i & bus.req_valid_i[n]
              & (infl_q[n] < MAXI);
  end

  always_comb begin
    accept = 1'b0;
    gidx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!accept && elig[wrap(ptr_q, i)]) begin
        accept = 1'b1;
        gidx   = wrap(ptr_q, i);
      end
    end
    accept = accept & ~reset_i;
    grant  = accept ? (NREQ'(1) << gidx) : '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= wrap(gidx, 1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      iv_q    <= 1'b0;
      imode_q <= 1'b0;
      ikey_q  <= '0;
      idata_q <= '0;
      iown_q  <= '0;
    end else begin
      iv_q <= accept;
      if (accept) begin
        imode_q <= bus.req_mode_i[gidx];
        ikey_q  <= bus.req_key_i[int'(gidx)*64 +: 64];
        idata_q <= bus.req_data_i[int'(gidx)*64 +: 64];
        iown_q  <= gidx;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int s = 0; s < TD; s++) begin
        tv_q[s] <= 1'b0;
        to_q[s] <= '0;
      end
    end else begin
      tv_q[0] <= iv_q;
      to_q[0] <= iown_q;
      for (int s = 1; s < TD; s++) begin
        tv_q[s] <= tv_q[s-1];
        to_q[s] <= to_q[s-1];
      end
    end
  end

  assign tail_v = tv_q[TD-1];
  assign tail_o = to_q[TD-1];
  assign hit    = bus.core_valid_i & tail_v;

  // a result without a matching tag is dropped and flagged
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rsp_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      rsp_q <= hit ? (NREQ'(1) << tail_o) : '0;
      if (hit) rdata_q <= bus.core_data_i;
      err_q <= err_q | (bus.core_valid_i ^ tail_v);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int n = 0; n < NREQ; n++) infl_q[n] <= '0;
    end else begin
      for (int n = 0; n < NREQ; n++) begin
        unique case ({grant[n], rsp_q[n]})
          2'b10:   infl_q[n] <= infl_q[n] + 5'd1;
          2'b01:   infl_q[n] <= infl_q[n] - 5'd1;
          default: infl_q[n] <= infl_q[n];
        endcase
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int n = 0; n < NREQ; n++)
      busy = busy | (infl_q[n] != 5'd0);
  end

  assign bus.req_ready_o  = grant;
  assign bus.core_valid_o = iv_q;
  assign bus.core_mode_o  = imode_q;
  assign bus.core_key_o   = ikey_q;
  assign bus.core_data_o  = idata_q;
  assign bus.rsp_valid_o  = rsp_q;
  assign bus.rsp_data_o   = rdata_q;
  assign bus.busy_o       = busy;
  assign bus.err_o        = err_q;
endmodule
